// File: rtl/rv_mul_ctrl.sv
// Sequencing controller for the byte-serial MUL datapath: clears the product,
// then accumulates the ten byte partial products that reach the low 32 bits.
module rv_mul_ctrl #(
  parameter int SEL_W   = 2,
  parameter int SHIFT_W = 5,
  parameter int BYTE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [SEL_W-1:0]   Ma_sel,
  output logic [SEL_W-1:0]   Mb_sel,
  output logic [SHIFT_W-1:0] Mshift_val,
  output logic               Mupd_prod,
  output logic               Mclr_prod
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] LAST_STEP = 4'd9;
  localparam int         BYTE_SH   = $clog2(BYTE_W);

  logic [1:0] state_q, state_d;
  logic [3:0] step_q, step_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = 4'd0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR;
      ST_CLR:  state_d = ST_RUN;
      ST_RUN: begin
        if (step_q == LAST_STEP) begin
          state_d = ST_DONE;
        end else if (step_q > LAST_STEP) begin
          // Unreachable step values fall back to IDLE rather than run on.
          state_d = ST_IDLE;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte-pair schedule; only pairs with i+j<=3 affect the low 32 bits.
  logic [SEL_W-1:0] sel_i, sel_j;
  logic             step_ok;

  always_comb begin
    sel_i   = '0;
    sel_j   = '0;
    step_ok = 1'b1;
    case (step_q)
      4'd0: begin sel_i = 2'd0; sel_j = 2'd0; end
      4'd1: begin sel_i = 2'd0; sel_j = 2'd1; end
      4'd2: begin sel_i = 2'd1; sel_j = 2'd0; end
      4'd3: begin sel_i = 2'd0; sel_j = 2'd2; end
      4'd4: begin sel_i = 2'd1; sel_j = 2'd1; end
      4'd5: begin sel_i = 2'd2; sel_j = 2'd0; end
      4'd6: begin sel_i = 2'd0; sel_j = 2'd3; end
      4'd7: begin sel_i = 2'd1; sel_j = 2'd2; end
      4'd8: begin sel_i = 2'd2; sel_j = 2'd1; end
      4'd9: begin sel_i = 2'd3; sel_j = 2'd0; end
      default: step_ok = 1'b0;
    endcase
  end

  logic [SEL_W-1:0] sel_sum;
  assign sel_sum = sel_i + sel_j;

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    Ma_sel     = '0;
    Mb_sel     = '0;
    Mshift_val = '0;
    Mupd_prod  = 1'b0;
    Mclr_prod  = 1'b0;
    case (state_q)
      ST_CLR: begin
        busy      = 1'b1;
        Mclr_prod = 1'b1;
      end
      ST_RUN: begin
        if (step_ok) begin
          busy       = 1'b1;
          Mupd_prod  = 1'b1;
          Ma_sel     = sel_i;
          Mb_sel     = sel_j;
          Mshift_val = SHIFT_W'(sel_sum) << BYTE_SH;
        end
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv_mul_ctrl.sv
// Directed bench for rv_mul_ctrl with a behavioural byte-serial product register
// driven by the controller outputs.
module tb_rv_mul_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, Mupd_prod, Mclr_prod;
  logic [1:0] Ma_sel, Mb_sel;
  logic [4:0] Mshift_val;

  logic [31:0] opa, opb, prod;
  logic [7:0]  a_byte, b_byte;

  int n_cmp = 0;
  int n_err = 0;

  int exp_i  [10] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3};
  int exp_j  [10] = '{0, 1, 0, 2, 1, 0, 3, 2, 1, 0};
  int exp_sh [10] = '{0, 8, 8, 16, 16, 16, 24, 24, 24, 24};

  rv_mul_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .Ma_sel     (Ma_sel),
    .Mb_sel     (Mb_sel),
    .Mshift_val (Mshift_val),
    .Mupd_prod  (Mupd_prod),
    .Mclr_prod  (Mclr_prod)
  );

  always #5 clk = ~clk;

  assign a_byte = opa[{Ma_sel, 3'b000} +: 8];
  assign b_byte = opb[{Mb_sel, 3'b000} +: 8];

  always @(posedge clk) begin
    if (Mclr_prod)      prod <= 32'd0;
    else if (Mupd_prod) prod <= prod + ((32'(a_byte) * 32'(b_byte)) << Mshift_val);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},  32'(busy),       32'd0);
    check({tag, " done"},  32'(done),       32'd0);
    check({tag, " asel"},  32'(Ma_sel),     32'd0);
    check({tag, " bsel"},  32'(Mb_sel),     32'd0);
    check({tag, " shift"}, 32'(Mshift_val), 32'd0);
    check({tag, " upd"},   32'(Mupd_prod),  32'd0);
    check({tag, " clr"},   32'(Mclr_prod),  32'd0);
  endtask

  // One MUL from a start pulse; cycle c is the c-th cycle after the sampling edge.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_prod, input string tag, input bit poke);
    int s;
    @(negedge clk);
    opa = a; opb = b; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      s = c - 2;
      check($sformatf("%s c%0d busy", tag, c), 32'(busy),      32'(c <= 12));
      check($sformatf("%s c%0d done", tag, c), 32'(done),      32'(c == 12));
      check($sformatf("%s c%0d clr",  tag, c), 32'(Mclr_prod), 32'(c == 1));
      check($sformatf("%s c%0d upd",  tag, c), 32'(Mupd_prod), 32'(c >= 2 && c <= 11));
      check($sformatf("%s c%0d asel", tag, c), 32'(Ma_sel),
            (c >= 2 && c <= 11) ? 32'(exp_i[s]) : 32'd0);
      check($sformatf("%s c%0d bsel", tag, c), 32'(Mb_sel),
            (c >= 2 && c <= 11) ? 32'(exp_j[s]) : 32'd0);
      check($sformatf("%s c%0d shift", tag, c), 32'(Mshift_val),
            (c >= 2 && c <= 11) ? 32'(exp_sh[s]) : 32'd0);
      if (c == 12) check({tag, " product"}, prod, exp_prod);
      start = poke && (c == 1 || c == 6 || c == 12);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    run_mul(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, "3x5",   1'b0);
    run_mul(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, "ffff",  1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "allf",  1'b0);
    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "ovf",   1'b0);
    run_mul(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, "poke",  1'b1);

    // Asynchronous reset in the middle of RUN step 5.
    @(negedge clk);
    opa = 32'd3; opb = 32'd5; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid step5 asel", 32'(Ma_sel), 32'd2);
    check("mid step5 upd",  32'(Mupd_prod), 32'd1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after rst");
    run_mul(32'd7, 32'd6, 32'h0000_002A, "7x6", 1'b0);

    // start held high: a new MUL every 13 cycles.
    @(negedge clk);
    opa = 32'd2; opb = 32'd9; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check($sformatf("held c%0d done", c), 32'(done),      32'((c % 13) == 12));
      check($sformatf("held c%0d clr",  c), 32'(Mclr_prod), 32'((c % 13) == 1));
      check($sformatf("held c%0d busy", c), 32'(busy),      32'((c % 13) != 0));
      if ((c % 13) == 12) check($sformatf("held c%0d product", c), prod, 32'd18);
    end
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("held drain done seen", 32'(seen), 32'd1);
    end
    @(negedge clk);
    check_idle_outputs("final idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
